// File: rtl/regfile_write_arbiter_if.sv
// Request/response bundle between the write-port requesters and the
// register-file write arbiter, plus the registered register-file write port.
interface regfile_write_arbiter_if #(
    parameter int DataWidth   = 8,
    parameter int NumRegs     = 16,
    parameter int IndexWidth  = $clog2(NumRegs),
    parameter int NumReq      = 2,
    parameter int ReqIdxWidth = $clog2(NumReq)
);
    logic [NumReq-1:0]            reqValid;
    logic [NumReq-1:0]            reqReady;
    logic [NumReq-1:0]            reqLock;
    logic [NumReq*IndexWidth-1:0] reqAddr;
    logic [NumReq*DataWidth-1:0]  reqData;
    logic                         writeEn;
    logic [IndexWidth-1:0]        writeAddr;
    logic [DataWidth-1:0]         writeData;
    logic [ReqIdxWidth-1:0]       lastGrant;
    logic                         locked;
    logic                         lockTimeout;

    modport master (
        output reqValid, reqLock, reqAddr, reqData,
        input  reqReady, writeEn, writeAddr, writeData, lastGrant, locked, lockTimeout
    );

    modport slave (
        input  reqValid, reqLock, reqAddr, reqData,
        output reqReady, writeEn, writeAddr, writeData, lastGrant, locked, lockTimeout
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NumReq
// requesters, with an optional per-requester lock that is force-released
// after LockTimeout idle cycles. The write port is registered.
// Build option REGFILE_ZERO_REG_EN: register 0 is hardwired zero, so accepts
// to address 0 complete the handshake but never raise writeEn.
module regfile_write_arbiter #(
    parameter int DataWidth   = 8,
    parameter int NumRegs     = 16,
    parameter int IndexWidth  = $clog2(NumRegs),
    parameter int NumReq      = 2,
    parameter int ReqIdxWidth = $clog2(NumReq),
    parameter int LockTimeout = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    regfile_write_arbiter_if.slave bus
);
    localparam int CntWidth = $clog2(LockTimeout + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                 state_q, state_d;
    logic [ReqIdxWidth-1:0] owner_q, owner_d;
    logic [ReqIdxWidth-1:0] last_q, last_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [IndexWidth-1:0]  waddr_q, waddr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   locked_q;
    logic                   timeout_q, timeout_d;

    logic                   accept;
    logic [ReqIdxWidth-1:0] gnt_idx;
    logic [NumReq-1:0]      ready;
    logic [IndexWidth-1:0]  sel_addr;
    logic [DataWidth-1:0]   sel_data;
    int                     scan_idx;

    // Grant selection: owner only while locked, else round-robin after lastGrant.
    // Scanning from the farthest offset down lets the nearest valid requester win.
    always_comb begin
        ready    = '0;
        accept   = 1'b0;
        gnt_idx  = last_q;
        scan_idx = 0;
        if (state_q == LOCKED) begin
            if (bus.reqValid[owner_q]) begin
                accept  = 1'b1;
                gnt_idx = owner_q;
            end
        end else begin
            for (int k = NumReq; k >= 1; k--) begin
                scan_idx = (int'(last_q) + k) % NumReq;
                if (bus.reqValid[scan_idx]) begin
                    accept  = 1'b1;
                    gnt_idx = ReqIdxWidth'(scan_idx);
                end
            end
        end
        if (accept) ready[gnt_idx] = 1'b1;
    end

    assign sel_addr = bus.reqAddr[int'(gnt_idx)*IndexWidth +: IndexWidth];
    assign sel_data = bus.reqData[int'(gnt_idx)*DataWidth +: DataWidth];

    // Next-state: lock FSM, idle timeout counter, grant history and write stage.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        last_d    = last_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        if (accept) begin
            last_d  = gnt_idx;
            we_d    = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
`ifdef REGFILE_ZERO_REG_EN
            // Register 0 reads as zero: swallow the write, keep the port values.
            if (sel_addr == '0) begin
                we_d    = 1'b0;
                waddr_d = waddr_q;
                wdata_d = wdata_q;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (accept && bus.reqLock[gnt_idx]) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!bus.reqLock[gnt_idx]) state_d = IDLE;
                end else if (cnt_q == CntWidth'(LockTimeout - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= ReqIdxWidth'(NumReq - 1);
            cnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            locked_q  <= (state_d == LOCKED);
            timeout_q <= timeout_d;
        end
    end

    assign bus.reqReady    = ready;
    assign bus.writeEn     = we_q;
    assign bus.writeAddr   = waddr_q;
    assign bus.writeData   = wdata_q;
    assign bus.lastGrant   = last_q;
    assign bus.locked      = locked_q;
    assign bus.lockTimeout = timeout_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;
    localparam int DW = 8;
    localparam int NREGS = 16;
    localparam int IW = 4;
    localparam int NR = 2;
    localparam int RW = 1;
    localparam int LT = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    int checks = 0;
    int failures = 0;

    regfile_write_arbiter_if #(.DataWidth(DW), .NumRegs(NREGS), .IndexWidth(IW),
                               .NumReq(NR), .ReqIdxWidth(RW)) bus ();

    regfile_write_arbiter #(.DataWidth(DW), .NumRegs(NREGS), .IndexWidth(IW),
                            .NumReq(NR), .ReqIdxWidth(RW), .LockTimeout(LT))
        dut (.clk(clk), .rstN(rstN), .bus(bus));

    always #5 clk = ~clk;

    // Register file driven by the DUT write port, and the model's own copy.
    logic [DW-1:0] rf_dut [NREGS];
    logic [DW-1:0] m_rf   [NREGS];

    // Model state.
    int            m_last  = NR - 1;
    int            m_owner = -1;
    int            m_idle  = 0;
    bit            m_we    = 1'b0;
    logic [IW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_to    = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which requester the rules say is granted this cycle (-1 = none).
    function automatic int grant_of(input logic [NR-1:0] v, input int owner, input int last);
        if (owner >= 0) return v[owner] ? owner : -1;
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Model: advance on each clock edge, collapse on reset.
    initial begin
        for (int r = 0; r < NREGS; r++) begin
            rf_dut[r] = '0;
            m_rf[r]   = '0;
        end
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                m_last = NR - 1; m_owner = -1; m_idle = 0;
                m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_to = 1'b0;
            end else begin
                int g;
                if (bus.writeEn) rf_dut[bus.writeAddr] = bus.writeData;
                if (m_we) m_rf[m_waddr] = m_wdata;
                g = grant_of(bus.reqValid, m_owner, m_last);
                m_we = 1'b0;
                m_to = 1'b0;
                if (g >= 0) begin
                    logic [IW-1:0] a;
                    a = bus.reqAddr[g*IW +: IW];
                    m_last = g;
                    if (!(ZERO && a == '0)) begin
                        m_we = 1'b1;
                        m_waddr = a;
                        m_wdata = bus.reqData[g*DW +: DW];
                    end
                    m_idle = 0;
                    if (m_owner < 0) begin
                        if (bus.reqLock[g]) m_owner = g;
                    end else if (!bus.reqLock[g]) begin
                        m_owner = -1;
                    end
                end else if (m_owner >= 0) begin
                    m_idle++;
                    if (m_idle == LT) begin
                        m_owner = -1;
                        m_idle = 0;
                        m_to = 1'b1;
                    end
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int g;
                logic [NR-1:0] er;
                g = grant_of(bus.reqValid, m_owner, m_last);
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                cmp("m_reqReady", 32'(bus.reqReady), 32'(er));
                cmp("m_writeEn", 32'(bus.writeEn), 32'(m_we));
                cmp("m_writeAddr", 32'(bus.writeAddr), 32'(m_waddr));
                cmp("m_writeData", 32'(bus.writeData), 32'(m_wdata));
                cmp("m_lastGrant", 32'(bus.lastGrant), 32'(m_last));
                cmp("m_locked", 32'(bus.locked), 32'(m_owner >= 0));
                cmp("m_lockTimeout", 32'(bus.lockTimeout), 32'(m_to));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int i, input bit v, input bit lk, input int a, input int d);
        bus.reqValid[i] = v;
        bus.reqLock[i]  = lk;
        bus.reqAddr[i*IW +: IW] = IW'(a);
        bus.reqData[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        rstN = 1'b0;
        bus.reqValid = '0;
        bus.reqLock  = '0;
        bus.reqAddr  = '0;
        bus.reqData  = '0;
        step(); step();
        cmp("rst_writeEn", 32'(bus.writeEn), 32'd0);
        cmp("rst_lastGrant", 32'(bus.lastGrant), 32'd1);
        cmp("rst_locked", 32'(bus.locked), 32'd0);
        @(negedge clk) rstN = 1'b1;
        step();

        // Both valid after reset: req0 first, req1 next, writeEn back-to-back.
        setreq(0, 1, 0, 3, 8'h11);
        setreq(1, 1, 0, 4, 8'h22);
        #1 cmp("t1_ready0", 32'(bus.reqReady), 32'b01);
        step();
        bus.reqValid[0] = 1'b0;
        #1 cmp("t1_ready1", 32'(bus.reqReady), 32'b10);
        cmp("t1_we0", 32'(bus.writeEn), 32'd1);
        cmp("t1_addr0", 32'(bus.writeAddr), 32'd3);
        cmp("t1_data0", 32'(bus.writeData), 32'h11);
        step();
        bus.reqValid[1] = 1'b0;
        cmp("t1_we1", 32'(bus.writeEn), 32'd1);
        cmp("t1_addr1", 32'(bus.writeAddr), 32'd4);
        step();
        cmp("t1_we_off", 32'(bus.writeEn), 32'd0);
        step();
        cmp("t1_rf3", 32'(rf_dut[3]), 32'h11);
        cmp("t1_rf4", 32'(rf_dut[4]), 32'h22);

        // Continuous contention alternates 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            setreq(0, 1, 0, 5, 8'h40 + i);
            setreq(1, 1, 0, 6, 8'h50 + i);
            #1 cmp("t2_ready", 32'(bus.reqReady), (i % 2) ? 32'b10 : 32'b01);
            step();
            cmp("t2_lastGrant", 32'(bus.lastGrant), 32'(i % 2));
            cmp("t2_we", 32'(bus.writeEn), 32'd1);
        end
        bus.reqValid = '0;
        step();

        // req1 lock burst while req0 waits.
        setreq(0, 1, 0, 8, 8'h60);
        step();
        for (int j = 0; j < 5; j++) begin
            setreq(1, 1, (j < 4), 9, 8'h70 + j);
            #1 cmp("t3_burst_ready", 32'(bus.reqReady), 32'b10);
            step();
            if (j < 4) cmp("t3_locked", 32'(bus.locked), 32'd1);
        end
        bus.reqValid[1] = 1'b0;
        #1 cmp("t3_post_ready", 32'(bus.reqReady), 32'b01);
        cmp("t3_unlocked", 32'(bus.locked), 32'd0);
        step();
        bus.reqValid = '0;
        step();

        // req0 locks then goes idle; timeout after 16 cycles, req1 next.
        setreq(0, 1, 1, 10, 8'h80);
        #1 cmp("t4_lock_ready", 32'(bus.reqReady), 32'b01);
        step();
        setreq(0, 0, 0, 10, 8'h80);
        setreq(1, 1, 0, 11, 8'h90);
        #1 cmp("t4_blocked", 32'(bus.reqReady), 32'b00);
        for (int k = 1; k <= LT; k++) begin
            step();
            if (k < LT) begin
                cmp("t4_to_early", 32'(bus.lockTimeout), 32'd0);
                cmp("t4_still_locked", 32'(bus.locked), 32'd1);
            end else begin
                cmp("t4_to_pulse", 32'(bus.lockTimeout), 32'd1);
                cmp("t4_released", 32'(bus.locked), 32'd0);
                cmp("t4_req1_ready", 32'(bus.reqReady), 32'b10);
            end
        end
        step();
        cmp("t4_to_once", 32'(bus.lockTimeout), 32'd0);
        cmp("t4_lastGrant", 32'(bus.lastGrant), 32'd1);
        bus.reqValid = '0;
        step();

        // Reset during a registered write drops it.
        setreq(0, 1, 0, 7, 8'h5A);
        step();
        bus.reqValid = '0;
        step(); step();
        setreq(0, 1, 0, 7, 8'h33);
        step();
        bus.reqValid = '0;
        cmp("t5_we_before", 32'(bus.writeEn), 32'd1);
        rstN = 1'b0;
        #1 cmp("t5_we_reset", 32'(bus.writeEn), 32'd0);
        @(negedge clk);
        @(negedge clk) rstN = 1'b1;
        step(); step();
        cmp("t5_rf7", 32'(rf_dut[7]), 32'h5A);

        // Write to register 0.
        setreq(0, 1, 0, 0, 8'hFF);
        #1 cmp("t6_ready", 32'(bus.reqReady), 32'b01);
        step();
        bus.reqValid = '0;
        cmp("t6_lastGrant", 32'(bus.lastGrant), 32'd0);
        cmp("t6_we", 32'(bus.writeEn), ZERO ? 32'd0 : 32'd1);
        step(); step();
        cmp("t6_rf0", 32'(rf_dut[0]), ZERO ? 32'h00 : 32'hFF);

        for (int r = 0; r < NREGS; r++) cmp("rf_final", 32'(rf_dut[r]), 32'(m_rf[r]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
